// File: rtl/out_port_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : out_port_uart_tx_pkg
// Description : Shared constants for the CPU output-port UART streamer.
//               Holds the UART serializer state encodings and the 8N1
//               frame geometry used by the serializer and its parent.
// Revision    : 1.0 - initial release
// ============================================================================
package out_port_uart_tx_pkg;

  // Serializer states; encodings are fixed so they read the same in
  // waveforms as in the design notes.
  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  // 8N1 frame geometry
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_START_BITS = 1;
  localparam int UART_STOP_BITS  = 1;
  localparam int UART_FRAME_BITS = UART_START_BITS + UART_DATA_BITS + UART_STOP_BITS;

endpackage
`default_nettype wire

// File: rtl/out_port_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : out_port_uart_tx_if
// Description : Bundle between the CPU output port and the UART streamer.
//               master : CPU side (drives data_i / ld_ni, sees status)
//               slave  : streamer side (takes data_i / ld_ni, drives
//                        tx_o, busy_o, full_o, overflow_o)
// Revision    : 1.0 - initial release
// ============================================================================
interface out_port_uart_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data_i;      // word from the CPU output mux
  logic                  ld_ni;       // active-low output-load strobe
  logic                  tx_o;        // UART line, idle high
  logic                  busy_o;      // FIFO non-empty or word in flight
  logic                  full_o;      // FIFO holds FIFO_DEPTH words
  logic                  overflow_o;  // sticky dropped-push flag

  modport master (
    output data_i, ld_ni,
    input  tx_o, busy_o, full_o, overflow_o
  );

  modport slave (
    input  data_i, ld_ni,
    output tx_o, busy_o, full_o, overflow_o
  );
endinterface
`default_nettype wire

// File: rtl/out_port_uart_tx_uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_tx
// Description : 8N1 byte serializer (start, 8 data bits LSB first, stop).
//   clk_i    in   system clock
//   reset_ni in   asynchronous active-low reset
//   start_i  in   accept byte_i (sampled in IDLE, or on the last STOP cycle)
//   byte_i   in   byte to send
//   tx_o     out  registered serial line, idle high
//   done_o   out  high on the final cycle of the stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx
  import out_port_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  wire logic       clk_i,
  input  wire logic       reset_ni,
  input  wire logic       start_i,
  input  wire logic [7:0] byte_i,
  output logic            tx_o,
  output logic            done_o
);

  localparam int            CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    C_BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_byte;
  logic          r_tx;

  logic          w_bit_end;
  logic [2:0]    w_bit_nxt;

  assign w_bit_end = (r_cnt == C_CNT_LAST);
  assign w_bit_nxt = r_bit + 3'd1;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= UART_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      case (r_state)
        UART_IDLE: begin
          r_cnt <= '0;
          r_tx  <= 1'b1;
          if (start_i) begin
            r_byte  <= byte_i;
            r_tx    <= 1'b0;
            r_state <= UART_START;
          end
        end
        UART_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= r_byte[0];
            r_state <= UART_DATA;
          end
        end
        UART_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == C_BIT_LAST) begin
              r_tx    <= 1'b1;
              r_state <= UART_STOP;
            end else begin
              r_bit <= w_bit_nxt;
              r_tx  <= r_byte[w_bit_nxt];
            end
          end
        end
        UART_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            // Chain the next byte straight into its start bit so the
            // bytes of one word leave with no idle gap between them.
            if (start_i) begin
              r_byte  <= byte_i;
              r_tx    <= 1'b0;
              r_state <= UART_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= UART_IDLE;
            end
          end
        end
        default: begin
          r_cnt   <= '0;
          r_tx    <= 1'b1;
          r_state <= UART_IDLE;
        end
      endcase
    end
  end

  assign tx_o   = r_tx;
  assign done_o = (r_state == UART_STOP) && w_bit_end;

endmodule
`default_nettype wire

// File: rtl/out_port_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : out_port_uart_tx
// Description : Captures every CPU output-port load into a small FIFO and
//               streams each word over UART 8N1, most-significant byte first.
//   clk_i    in   system clock
//   reset_ni in   asynchronous active-low reset
//   bus      slave modport: data_i/ld_ni in; tx_o/busy_o/full_o/overflow_o out
// Revision    : 1.0 - initial release
// ============================================================================
module out_port_uart_tx
  import out_port_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  wire logic            clk_i,
  input  wire logic            reset_ni,
  out_port_uart_tx_if.slave    bus
);

  localparam int NB = DATA_WIDTH / UART_DATA_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] C_IDX_TOP = IW'(NB - 1);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr;
  logic [PW-1:0]         r_rd;
  logic                  r_ovf;
  logic                  r_active;   // a word is being serialized
  logic [IW-1:0]         r_idx;      // byte index currently on the line
  logic [NB-1:0][7:0]    r_sw;       // shift word popped from the FIFO

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push_req;
  logic                  w_push;
  logic [NB-1:0][7:0]    w_head;
  logic                  w_done;
  logic                  w_start_first;
  logic                  w_start_next;
  logic                  w_start;
  logic [IW-1:0]         w_idx_dec;
  logic [7:0]            w_byte;
  logic                  w_tx;

  assign w_empty    = (r_wr == r_rd);
  assign w_full     = (r_wr[PW-1] != r_rd[PW-1]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push_req = !bus.ld_ni;
  // Full is judged on the pre-edge state, so a same-cycle pop never
  // rescues a push into a full FIFO.
  assign w_push     = w_push_req && !w_full;
  assign w_head     = r_mem[r_rd[AW-1:0]];

  // The first byte of a word comes straight from the FIFO head so the start
  // bit begins in the cycle right after the pop.
  assign w_start_first = !r_active && !w_empty;
  assign w_start_next  = r_active && w_done && (r_idx != '0);
  assign w_start       = w_start_first || w_start_next;
  assign w_idx_dec     = r_idx - 1'b1;
  assign w_byte        = w_start_first ? w_head[C_IDX_TOP] : r_sw[w_idx_dec];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= bus.data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_ovf    <= 1'b0;
      r_active <= 1'b0;
      r_idx    <= '0;
      r_sw     <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end
      if (w_start_first) begin
        r_rd     <= r_rd + 1'b1;
        r_sw     <= w_head;
        r_idx    <= C_IDX_TOP;
        r_active <= 1'b1;
      end else if (w_start_next) begin
        r_idx <= w_idx_dec;
      end else if (r_active && w_done) begin
        r_active <= 1'b0;
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_tx (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .start_i  (w_start),
    .byte_i   (w_byte),
    .tx_o     (w_tx),
    .done_o   (w_done)
  );

  assign bus.tx_o       = w_tx;
  assign bus.busy_o     = !w_empty || r_active;
  assign bus.full_o     = w_full;
  assign bus.overflow_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_out_port_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_port_uart_tx
// Description : Self-checking bench for out_port_uart_tx (16-bit words,
//               4 clocks per bit, 4-entry FIFO). A word-level reference
//               model expands each accepted word into its expected line
//               waveform and every output is compared once per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_port_uart_tx;

  localparam int DW    = 16;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int NB    = DW / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  out_port_uart_tx_if #(.DATA_WIDTH(DW)) u_if ();

  out_port_uart_tx #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (u_if.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_fifo[$];   // accepted words not yet popped
  logic          m_wave[$];   // future tx levels, one per cycle
  logic          m_wbusy[$];  // whether that cycle belongs to a word
  logic          m_tx   = 1'b1;
  logic          m_bf   = 1'b0;
  logic          m_ovf  = 1'b0;

  task automatic model_reset();
    m_fifo.delete();
    m_wave.delete();
    m_wbusy.delete();
    m_tx  = 1'b1;
    m_bf  = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic ld_n, input logic [DW-1:0] d);
    logic          full_b;
    logic [DW-1:0] w;
    logic [7:0]    b;
    logic [9:0]    frame;
    full_b = (m_fifo.size() == DEPTH);
    // Transmitter free and a word waiting: the word's whole line image
    // (bytes MSB first, 8N1 each) plus one idle cycle is scheduled.
    if (m_wave.size() == 0 && m_fifo.size() > 0) begin
      w = m_fifo.pop_front();
      for (int k = NB - 1; k >= 0; k--) begin
        b     = 8'(w >> (8 * k));
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
          for (int c = 0; c < CPB; c++) begin
            m_wave.push_back(frame[i]);
            m_wbusy.push_back(1'b1);
          end
        end
      end
      m_wave.push_back(1'b1);
      m_wbusy.push_back(1'b0);
    end
    if (!ld_n) begin
      if (full_b) m_ovf = 1'b1;
      else        m_fifo.push_back(d);
    end
    if (m_wave.size() > 0) begin
      m_tx = m_wave.pop_front();
      m_bf = m_wbusy.pop_front();
    end else begin
      m_tx = 1'b1;
      m_bf = 1'b0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("tx",       32'(u_if.tx_o),       32'(m_tx));
    chk("busy",     32'(u_if.busy_o),     32'(m_fifo.size() > 0 || m_bf));
    chk("full",     32'(u_if.full_o),     32'(m_fifo.size() == DEPTH));
    chk("overflow", 32'(u_if.overflow_o), 32'(m_ovf));
  endtask

  // One clock: drive inputs (just after negedge), apply the edge to the
  // model, then compare outputs at the following negedge.
  task automatic cycle(input logic ld_n, input logic [DW-1:0] d);
    u_if.ld_ni  = ld_n;
    u_if.data_i = d;
    @(posedge clk);
    model_edge(ld_n, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, '0);
  endtask

  logic s_tx[120];
  int   busy_cnt;
  int   run;

  initial begin
    u_if.ld_ni  = 1'b1;
    u_if.data_i = '0;
    model_reset();

    // Reset state, observed while reset is held
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx",   32'(u_if.tx_o),       32'd1);
    chk("rst_busy", 32'(u_if.busy_o),     32'd0);
    chk("rst_full", 32'(u_if.full_o),     32'd0);
    chk("rst_ovf",  32'(u_if.overflow_o), 32'd0);
    rst_n = 1'b1;

    // Quiet line for 200 cycles
    idle(200);

    // Single word 0xA55A: frame timing and busy duration
    cycle(1'b0, 16'hA55A);
    busy_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      cycle(1'b1, '0);
      s_tx[i] = u_if.tx_o;
      if (u_if.busy_o) busy_cnt++;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd80);
    chk("f0_start",    32'(s_tx[0]),  32'd0);
    chk("f0_stop",     32'(s_tx[39]), 32'd1);
    chk("f1_start",    32'(s_tx[40]), 32'd0);
    chk("f1_stop",     32'(s_tx[79]), 32'd1);
    run = 1;
    for (int i = 1; i < 80; i++) begin
      if (s_tx[i] == s_tx[i-1]) begin
        run++;
      end else begin
        chk("run_len_mod4", 32'(run % CPB), 32'd0);
        run = 1;
      end
    end
    chk("last_run_mod4", 32'(run % CPB), 32'd0);

    // Six back-to-back pushes: full after the fifth, sixth dropped
    for (int i = 1; i <= 5; i++) cycle(1'b0, DW'(i));
    chk("full_after5", 32'(u_if.full_o), 32'd1);
    cycle(1'b0, 16'h0006);
    chk("ovf_after6", 32'(u_if.overflow_o), 32'd1);
    idle(5 * 81 + 20);
    chk("ovf_sticky", 32'(u_if.overflow_o), 32'd1);

    // Fresh start to clear the sticky flag
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Push while a frame is in flight
    cycle(1'b0, 16'h1111);
    idle(17);
    cycle(1'b0, 16'h2222);
    idle(200);

    // Reset mid-DATA of the first byte of 0xFFFF
    cycle(1'b0, 16'hFFFF);
    idle(9);
    rst_n = 1'b0;
    #1;
    chk("arst_tx",   32'(u_if.tx_o),       32'd1);
    chk("arst_busy", 32'(u_if.busy_o),     32'd0);
    chk("arst_full", 32'(u_if.full_o),     32'd0);
    chk("arst_ovf",  32'(u_if.overflow_o), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    cycle(1'b0, 16'h1234);
    idle(200);

    // Randomized traffic: alternate light and bursty phases
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 300; i++) begin
        cycle(($urandom_range(0, 99) < ((p % 2) ? 40 : 3)) ? 1'b0 : 1'b1, DW'($urandom));
      end
    end
    idle(DEPTH * 81 + 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/out_port_uart_tx.md
Name: out_port_uart_tx

Overview:
- Consumer of the CPU output-port write strobe: captures each word the CPU loads into its output register.
- Buffers words in a small FIFO and sends each one over a UART 8N1 TX line, most-significant byte first.
- Sits beside the CPU at the top level; fed by the CPU's output data and its active-low output-load strobe.
- Gives the board a serial debug/console stream in place of LED-only visual debug.

Parameters:
- DATA_WIDTH, 16: word width; must be a multiple of 8. Bytes per word NB = DATA_WIDTH/8.
- CLKS_PER_BIT, 104: clock cycles per UART bit; must be ≥ 2. The default suits 12 MHz at 115200 baud.
- FIFO_DEPTH, 4: number of word entries; must be a power of 2 and ≥ 2.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- reset_ni  in  1  reset; asynchronous assert, active-low.
- data_i  in  DATA_WIDTH  word from the CPU output mux.
- ld_ni  in  1  active-low write strobe. Each rising edge with ld_ni=0 is one push attempt.
- tx_o  out  1  UART serial line; idle high.
- busy_o  out  1  high while the FIFO is non-empty or a word is being sent.
- full_o  out  1  FIFO holds FIFO_DEPTH words.
- overflow_o  out  1  sticky; set when a push is dropped.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (clk_i, reset_ni).
  - While reset_ni=0: tx_o=1, busy_o=0, full_o=0, overflow_o=0, FIFO empty, FSM=IDLE, counters=0. These take effect immediately, with no clock needed.
  - Reset mid-frame aborts the frame; tx_o returns high at once. Partial bytes are never resumed.
- FIFO:
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - full = MSBs differ and the remaining bits are equal; empty = pointers equal.
  - Push on ld_ni=0 when not full. If full (evaluated before any same-cycle pop), the word is dropped and overflow_o sets; overflow_o clears only on reset.
  - Simultaneous push and pop while non-full: both occur, count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into shift word sw, set byte index to NB-1, go to START. Otherwise tx_o=1.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_o = current byte[bit], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. If byte index > 0: decrement it and go straight to START (no gap). Otherwise go to IDLE.
- Byte selection: byte k = sw[8k+7:8k]; the highest k is sent first.
- Latency:
  - A push at edge N makes the FIFO non-empty after N.
  - IDLE pops at edge N+1; tx_o falls after edge N+1, i.e. low in the cycle following N+1.
  - One word occupies NB*10*CLKS_PER_BIT cycles plus 1 IDLE cycle before the next word.
- busy_o = !empty || state != IDLE; registered or combinational from registered state, glitch-free.
- The baud counter counts 0..CLKS_PER_BIT-1 and is reset on every state entry. Its width is clog2(CLKS_PER_BIT).

Decomposition:
- Shared constants include (same place as the existing opcode constants): UART state encodings (IDLE=0, START=1, DATA=2, STOP=3) and frame constants (8 data bits, 1 start bit, 1 stop bit).
- Sub-module uart_byte_tx (clk_i, reset_ni, start_i, byte_i, tx_o, done_o) holds the START/DATA/STOP serializer and baud counter.
- Parent holds the FIFO, word/byte sequencing and flags.

Test Plan (DATA_WIDTH=16, CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single push of 0xA55A at edge N:
  - tx_o low from N+1 for 4 cycles, then 1,0,1,0,0,1,0,1 (0xA5 LSB first, 4 cycles each), stop high for 4 cycles.
  - Immediately followed by a frame for 0x5A.
  - busy_o falls 80 cycles after N+1.
- Six consecutive pushes 0x0001..0x0006 from idle:
  - Word 1 pops at the second edge; full_o asserts after the fifth push; the sixth push is dropped and overflow_o=1.
  - Serial stream decodes as 0x0001..0x0005 in order; overflow_o stays 1 afterwards.
- Push while a frame is in flight with the FIFO non-full: no disturbance to current bit timing; the word is sent after exactly 1 IDLE cycle.
- reset_ni pulsed low mid-DATA of the first byte of 0xFFFF:
  - tx_o=1 and busy_o=0 asynchronously.
  - After release, no residual frame; a fresh push of 0x1234 sends exactly 0x12, 0x34.
- ld_ni held high for 200 cycles after reset: tx_o constant 1, busy_o=0, full_o=0, overflow_o=0.
- Bit-period check: every tx_o level run is a multiple of 4 cycles; each 10-bit frame measures exactly 40 cycles.
